// File: rtl/pong_ball_engine.sv
`timescale 1ns/1ps
// Pong ball engine: sub-pixel ball motion with paddle/wall reflection,
// serve/miss sequencing, speed-up on hits and optional slow curving.

// Registered sine lookup with amplitude 127 built from a quarter-wave table.
module pong_sin_lut #(
    parameter int THETA_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [THETA_WIDTH-1:0] theta_i,
    output logic signed [7:0]      sin_o
);
    logic [5:0] phase;
    logic [4:0] k;
    logic [6:0] mag;

    // Map the angle onto a 64-step circle.
    if (THETA_WIDTH >= 6) begin : g_down
        assign phase = theta_i[THETA_WIDTH-1 -: 6];
    end else begin : g_up
        assign phase = {theta_i, {(6-THETA_WIDTH){1'b0}}};
    end

    function automatic logic [6:0] quarter(input logic [4:0] idx);
        logic [6:0] v;
        case (idx)
            5'd0:    v = 7'd0;
            5'd1:    v = 7'd12;
            5'd2:    v = 7'd25;
            5'd3:    v = 7'd37;
            5'd4:    v = 7'd49;
            5'd5:    v = 7'd60;
            5'd6:    v = 7'd71;
            5'd7:    v = 7'd81;
            5'd8:    v = 7'd90;
            5'd9:    v = 7'd98;
            5'd10:   v = 7'd106;
            5'd11:   v = 7'd112;
            5'd12:   v = 7'd117;
            5'd13:   v = 7'd122;
            5'd14:   v = 7'd125;
            5'd15:   v = 7'd126;
            default: v = 7'd127;
        endcase
        return v;
    endfunction

    // Fold the phase into the first quadrant and look up the magnitude.
    always_comb begin
        k   = phase[4] ? (5'd16 - {1'b0, phase[3:0]}) : {1'b0, phase[3:0]};
        mag = quarter(k);
    end

    // Register the signed result; the lower half-circle is negative.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sin_o <= '0;
        end else begin
            sin_o <= phase[5] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        end
    end
endmodule

module pong_ball_engine #(
    parameter int X_BITS      = 4,
    parameter int Y_BITS      = 4,
    parameter int FRAC_BITS   = 17,
    parameter int THETA_WIDTH = 6,
    parameter int SPEED_W     = 5,
    parameter int MAX_SPEED   = 15,
    parameter int ROT_PERIOD  = 500,
    parameter int HOLD_TICKS  = 1000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     tick,
    input  logic                     serve,
    input  logic                     serve_dir,
    input  logic [SPEED_W-1:0]       base_speed,
    input  logic                     curve_en,
    input  logic [(1<<Y_BITS)-1:0]   lpaddle,
    input  logic [(1<<Y_BITS)-1:0]   rpaddle,
    output logic [X_BITS-1:0]        x,
    output logic [Y_BITS-1:0]        y,
    output logic [THETA_WIDTH-1:0]   theta,
    output logic [SPEED_W-1:0]       speed,
    output logic                     in_play,
    output logic                     hit,
    output logic                     miss_l,
    output logic                     miss_r
);
    localparam int PW_X = X_BITS + FRAC_BITS;
    localparam int PW_Y = Y_BITS + FRAC_BITS;
    localparam int RW   = $clog2(ROT_PERIOD + 1);
    localparam int HW   = $clog2(HOLD_TICKS + 1);

    localparam logic [PW_X-1:0] HOR_C = {1'b1, {(PW_X-1){1'b0}}};
    localparam logic [PW_Y-1:0] VERT_C = {1'b1, {(PW_Y-1){1'b0}}};
    localparam logic [THETA_WIDTH-1:0] TH_HALF =
        {1'b1, {(THETA_WIDTH-1){1'b0}}};
    localparam logic [THETA_WIDTH-1:0] TH_QTR =
        {2'b01, {(THETA_WIDTH-2){1'b0}}};
    localparam logic [X_BITS-1:0]  X_MAX     = '1;
    localparam logic [SPEED_W-1:0] SPD_MAX   = SPEED_W'(MAX_SPEED);
    localparam logic [RW-1:0]      ROT_LAST  = RW'(ROT_PERIOD - 1);
    localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_MISS
    } state_e;

    state_e                   state_q;
    logic                     tick_q;
    logic [PW_X-1:0]          hor_q;
    logic [PW_Y-1:0]          vert_q;
    logic [THETA_WIDTH-1:0]   theta_q;
    logic [SPEED_W-1:0]       speed_q;
    logic [RW-1:0]            rot_q;
    logic                     pend_q;
    logic [HW-1:0]            hold_q;
    logic                     in_play_q;
    logic                     hit_q;
    logic                     miss_l_q;
    logic                     miss_r_q;

    logic signed [7:0]        sin_v;
    logic signed [7:0]        cos_v;
    logic [THETA_WIDTH-1:0]   cos_theta;

    logic signed [PW_X-1:0]   cos_w, spdx_w, dx;
    logic signed [PW_Y-1:0]   sin_w, spdy_w, dy;
    logic [PW_X-1:0]          hor_d;
    logic [PW_Y-1:0]          vert_d;
    logic [X_BITS-1:0]        x_c, nx;
    logic [Y_BITS-1:0]        y_c, ny;
    logic                     left_mv, up_mv;
    logic                     pad_hit, mis_l, mis_r, wall;
    logic                     rot_wrap, consume;
    logic [SPEED_W-1:0]       spd_up;

    assign cos_theta = theta_q + TH_QTR;

    pong_sin_lut #(.THETA_WIDTH(THETA_WIDTH)) u_sin (
        .clk     (clk),
        .reset_n (reset_n),
        .theta_i (theta_q),
        .sin_o   (sin_v)
    );

    pong_sin_lut #(.THETA_WIDTH(THETA_WIDTH)) u_cos (
        .clk     (clk),
        .reset_n (reset_n),
        .theta_i (cos_theta),
        .sin_o   (cos_v)
    );

    // Candidate step and the reflection/miss conditions it would cause.
    always_comb begin
        cos_w   = PW_X'(cos_v);
        spdx_w  = PW_X'(speed_q);
        dx      = cos_w * spdx_w;
        sin_w   = PW_Y'(sin_v);
        spdy_w  = PW_Y'(speed_q);
        dy      = sin_w * spdy_w;
        hor_d   = hor_q + dx;
        vert_d  = vert_q + dy;
        x_c     = hor_q[PW_X-1 -: X_BITS];
        y_c     = vert_q[PW_Y-1 -: Y_BITS];
        nx      = hor_d[PW_X-1 -: X_BITS];
        ny      = vert_d[PW_Y-1 -: Y_BITS];
        left_mv = (theta_q[THETA_WIDTH-1] == theta_q[THETA_WIDTH-2]);
        up_mv   = theta_q[THETA_WIDTH-1];
        pad_hit = left_mv ? ((nx == X_MAX) && lpaddle[ny])
                          : ((nx == '0) && rpaddle[ny]);
        mis_l   = left_mv && (nx < x_c);
        mis_r   = !left_mv && (nx > x_c);
        wall    = up_mv ? ((y_c == '0) && (ny != '0))
                        : ((y_c != '0) && (ny == '0));
        rot_wrap = (rot_q == ROT_LAST);
        consume  = !pad_hit && !mis_l && !mis_r && !wall
                   && pend_q && curve_en;
        spd_up   = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 1'b1;
    end

    // Serve / play / miss-hold sequencer with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            tick_q    <= 1'b0;
            hor_q     <= HOR_C;
            vert_q    <= VERT_C;
            theta_q   <= '0;
            speed_q   <= '0;
            rot_q     <= '0;
            pend_q    <= 1'b0;
            hold_q    <= '0;
            in_play_q <= 1'b0;
            hit_q     <= 1'b0;
            miss_l_q  <= 1'b0;
            miss_r_q  <= 1'b0;
        end else begin
            hit_q    <= 1'b0;
            miss_l_q <= 1'b0;
            miss_r_q <= 1'b0;
            tick_q   <= tick && !tick_q && (state_q != S_IDLE);
            unique case (state_q)
                S_IDLE: begin
                    if (serve) begin
                        theta_q   <= serve_dir ? TH_HALF : '0;
                        speed_q   <= base_speed;
                        rot_q     <= '0;
                        pend_q    <= 1'b0;
                        in_play_q <= 1'b1;
                        state_q   <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (tick_q) begin
                        rot_q  <= rot_wrap ? '0 : rot_q + 1'b1;
                        pend_q <= rot_wrap || (pend_q && !consume);
                        if (pad_hit) begin
                            hit_q   <= 1'b1;
                            speed_q <= spd_up;
                            if (wall) begin
                                theta_q <= theta_q + TH_HALF;
                            end else begin
                                theta_q <= TH_HALF - theta_q;
                                vert_q  <= vert_d;
                            end
                        end else if (mis_l || mis_r) begin
                            miss_l_q  <= mis_l;
                            miss_r_q  <= mis_r;
                            hold_q    <= '0;
                            in_play_q <= 1'b0;
                            state_q   <= S_MISS;
                        end else if (wall) begin
                            theta_q <= '0 - theta_q;
                            hor_q   <= hor_d;
                        end else begin
                            hor_q  <= hor_d;
                            vert_q <= vert_d;
                            if (consume) begin
                                theta_q <= theta_q + 1'b1;
                            end
                        end
                    end
                end
                S_MISS: begin
                    if (tick_q) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_q  <= '0;
                            hor_q   <= HOR_C;
                            vert_q  <= VERT_C;
                            state_q <= S_IDLE;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign x       = hor_q[PW_X-1 -: X_BITS];
    assign y       = vert_q[PW_Y-1 -: Y_BITS];
    assign theta   = theta_q;
    assign speed   = speed_q;
    assign in_play = in_play_q;
    assign hit     = hit_q;
    assign miss_l  = miss_l_q;
    assign miss_r  = miss_r_q;
endmodule

// File: tb/tb_pong_ball_engine.sv
`timescale 1ns/1ps
// Bench for pong_ball_engine: directed scenarios plus randomized play
// compared against a trigonometric reference model of the ball.
module tb_pong_ball_engine;
    localparam int XB = 4, YB = 4, FB = 10, TW = 6, SW = 5;
    localparam int MAXS = 15, ROTP = 20, HOLDT = 12;
    localparam int N = 1 << TW;
    localparam int MX = 1 << (XB + FB);
    localparam int MY = 1 << (YB + FB);

    logic clk = 0, reset_n = 0, tick = 0, serve = 0;
    logic serve_dir = 0, curve_en = 0;
    logic [SW-1:0] base_speed = '0;
    logic [15:0] lpaddle = '0, rpaddle = '0;
    logic [XB-1:0] x;
    logic [YB-1:0] y;
    logic [TW-1:0] theta;
    logic [SW-1:0] speed;
    logic in_play, hit, miss_l, miss_r;

    pong_ball_engine #(
        .X_BITS(XB), .Y_BITS(YB), .FRAC_BITS(FB), .THETA_WIDTH(TW),
        .SPEED_W(SW), .MAX_SPEED(MAXS), .ROT_PERIOD(ROTP),
        .HOLD_TICKS(HOLDT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .serve(serve),
        .serve_dir(serve_dir), .base_speed(base_speed),
        .curve_en(curve_en), .lpaddle(lpaddle), .rpaddle(rpaddle),
        .x(x), .y(y), .theta(theta), .speed(speed), .in_play(in_play),
        .hit(hit), .miss_l(miss_l), .miss_r(miss_r)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    // reference model: 0 idle, 1 play, 2 miss-hold
    int m_st, m_hor, m_vert, m_th, m_spd, m_rot, m_hold;
    bit m_pend, m_hit, m_ml, m_mr;
    bit last_hit, last_ml, last_mr;

    function automatic int lut(int th);
        real r;
        r = 127.0 * $sin(2.0 * 3.141592653589793 * th / N);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_hor = MX / 2; m_vert = MY / 2; m_th = 0; m_spd = 0;
        m_rot = 0; m_hold = 0; m_pend = 0; m_hit = 0; m_ml = 0; m_mr = 0;
    endtask

    task automatic model_tick();
        int dx, dy, nh, nv, x0, y0, nx, ny;
        bit left, up, ph, ml, mr, wl, wrap, used;
        m_hit = 0; m_ml = 0; m_mr = 0;
        if (m_st == 2) begin
            m_hold++;
            if (m_hold == HOLDT) begin
                m_st = 0; m_hor = MX / 2; m_vert = MY / 2;
            end
        end else if (m_st == 1) begin
            dx = lut((m_th + N / 4) % N) * m_spd;
            dy = lut(m_th) * m_spd;
            nh = ((m_hor + dx) % MX + MX) % MX;
            nv = ((m_vert + dy) % MY + MY) % MY;
            x0 = m_hor >> FB; y0 = m_vert >> FB;
            nx = nh >> FB; ny = nv >> FB;
            left = (m_th < N / 4) || (m_th >= 3 * N / 4);
            up = (m_th >= N / 2);
            ph = left ? (nx == (1 << XB) - 1 && lpaddle[ny] == 1'b1)
                      : (nx == 0 && rpaddle[ny] == 1'b1);
            ml = left && (nx < x0);
            mr = !left && (nx > x0);
            wl = up ? (y0 == 0 && ny != 0) : (y0 != 0 && ny == 0);
            m_rot++;
            wrap = (m_rot == ROTP);
            if (wrap) m_rot = 0;
            used = 0;
            if (ph) begin
                m_hit = 1;
                m_spd = (m_spd + 1 < MAXS) ? m_spd + 1 : MAXS;
                if (wl) m_th = (m_th + N / 2) % N;
                else begin
                    m_th = (N / 2 - m_th + N) % N;
                    m_vert = nv;
                end
            end else if (ml || mr) begin
                m_ml = ml; m_mr = mr; m_st = 2; m_hold = 0;
            end else if (wl) begin
                m_th = (N - m_th) % N;
                m_hor = nh;
            end else begin
                m_hor = nh; m_vert = nv;
                if (m_pend && curve_en) begin
                    m_th = (m_th + 1) % N;
                    used = 1;
                end
            end
            m_pend = wrap || (m_pend && !used);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".x"}, 32'(x), 32'(m_hor >> FB));
        chk({tag, ".y"}, 32'(y), 32'(m_vert >> FB));
        chk({tag, ".theta"}, 32'(theta), 32'(m_th));
        chk({tag, ".speed"}, 32'(speed), 32'(m_spd));
        chk({tag, ".in_play"}, 32'(in_play), 32'(m_st == 1));
        chk({tag, ".hit"}, 32'(hit), 32'(m_hit));
        chk({tag, ".miss_l"}, 32'(miss_l), 32'(m_ml));
        chk({tag, ".miss_r"}, 32'(miss_r), 32'(m_mr));
    endtask

    task automatic do_tick(string tag);
        @(negedge clk); tick = 1;
        @(negedge clk); tick = 0;
        @(posedge clk); #1;
        model_tick();
        check_all(tag);
        last_hit = hit; last_ml = miss_l; last_mr = miss_r;
        @(posedge clk); #1;
        chk({tag, ".hit_width"}, 32'(hit), 32'd0);
        chk({tag, ".miss_width"}, 32'({miss_l, miss_r}), 32'd0);
    endtask

    task automatic do_serve(bit dir, int spd);
        @(negedge clk);
        serve = 1; serve_dir = dir; base_speed = SW'(spd);
        @(posedge clk); #1;
        if (m_st == 0) begin
            m_th = dir ? N / 2 : 0; m_spd = spd;
            m_rot = 0; m_pend = 0; m_st = 1;
        end
        m_hit = 0; m_ml = 0; m_mr = 0;
        check_all("serve");
        @(negedge clk); serve = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_hold(string tag);
        for (int i = 0; i < HOLDT + 2 && m_st == 2; i++) do_tick(tag);
    endtask

    initial begin
        int nml, nmr, maxx;
        bit seen;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_all("reset");
        reset_n = 1;
        repeat (2) @(negedge clk);

        do_tick("idle_tick");

        // Straight serve to the left with no paddle.
        nml = 0; maxx = 0;
        do_serve(0, 4);
        for (int i = 0; i < 100 && m_st == 1; i++) begin
            do_tick("serve_left");
            if (last_ml) nml++;
            if (int'(x) > maxx) maxx = int'(x);
        end
        chk("serve_left.miss_count", 32'(nml), 32'd1);
        chk("serve_left.max_x", 32'(maxx), 32'd15);

        // Hold after a miss; a serve during the hold is ignored.
        for (int i = 0; i < HOLDT + 2 && m_st == 2; i++) begin
            if (i == 3) do_serve(1, 9);
            do_tick("hold");
        end
        chk("hold.centre_x", 32'(x), 32'd8);
        chk("hold.centre_y", 32'(y), 32'd8);

        // Paddle return from the left, then a miss on the right.
        lpaddle = 16'hFFFF; rpaddle = '0;
        do_serve(0, 4);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            do_tick("return");
            if (last_hit) seen = 1;
        end
        chk("return.hit_seen", 32'(seen), 32'd1);
        chk("return.theta", 32'(theta), 32'd32);
        chk("return.speed", 32'(speed), 32'd5);
        nmr = 0;
        for (int i = 0; i < 300 && m_st == 1; i++) begin
            do_tick("return_out");
            if (last_mr) nmr++;
        end
        chk("return.miss_r_count", 32'(nmr), 32'd1);
        run_hold("hold2");

        // Enclosed court with curving: walls and corners come from rotation.
        lpaddle = 16'hFFFF; rpaddle = 16'hFFFF; curve_en = 1;
        do_serve(0, 6);
        for (int i = 0; i < 700 && m_st == 1; i++) do_tick("court");
        lpaddle = '0; rpaddle = '0; curve_en = 0;
        for (int i = 0; i < 400 && m_st == 1; i++) do_tick("court_out");
        run_hold("hold3");

        // Randomized paddles, curving and serves.
        for (int r = 0; r < 3; r++) begin
            do_serve(1'($urandom_range(0, 1)), $urandom_range(1, 12));
            for (int i = 0; i < 400 && m_st == 1; i++) begin
                lpaddle = 16'($urandom) | 16'($urandom);
                rpaddle = 16'($urandom) | 16'($urandom);
                curve_en = 1'($urandom_range(0, 1));
                if (i == 40) do_serve(1'($urandom_range(0, 1)), 3);
                do_tick("rand");
            end
            lpaddle = '0; rpaddle = '0;
            for (int i = 0; i < 400 && m_st == 1; i++) do_tick("rand_out");
            run_hold("rand_hold");
        end

        // Asynchronous reset with a step already sampled.
        do_serve(0, 7);
        for (int i = 0; i < 5; i++) do_tick("pre_reset");
        @(negedge clk); tick = 1;
        @(posedge clk); #2;
        reset_n = 0; tick = 0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk); reset_n = 1;
        @(posedge clk); #1;
        check_all("after_reset");
        @(posedge clk); #1;
        check_all("after_reset2");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pong_ball_engine.md
# pong_ball_engine

Parametrised successor to the free-running ball mover: advances the ball on an enable tick, reflects it off the top and bottom walls and off the paddles, and detects misses. It adds a serve/miss state machine, speed-up on every paddle hit and well-defined corner bounces. It sits between the paddle controllers and the display scanner, and its miss pulses drive the score counters.

## Interface
- `X_BITS`, 4: screen column index width; x = `2^X_BITS-1` is the left paddle column, x = 0 is the right paddle column.
- `Y_BITS`, 4: screen row index width.
- `FRAC_BITS`, 17: sub-pixel fraction bits per axis.
- `THETA_WIDTH`, 6: angle resolution; N = `2^THETA_WIDTH` steps per turn.
- `SPEED_W`, 5: speed width (unsigned).
- `MAX_SPEED`, 15: speed ceiling after speed-ups.
- `ROT_PERIOD`, 500: ticks between curving increments.
- `HOLD_TICKS`, 1000: ticks the ball stays frozen after a miss.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `tick` in 1: movement strobe, one `clk` wide; nominal rate 2 kHz.
- `serve` in 1: serve request pulse.
- `serve_dir` in 1: 0 = serve toward left (theta 0), 1 = toward right (theta N/2).
- `base_speed` in SPEED_W: speed loaded at serve.
- `curve_en` in 1: enables gradual rotation.
- `lpaddle`, `rpaddle` in `2^Y_BITS`: paddle occupancy per row.
- `x` out X_BITS, `y` out Y_BITS: integer ball position.
- `theta` out THETA_WIDTH: current direction.
- `speed` out SPEED_W: current speed.
- `in_play` out 1: high in PLAY.
- `hit` out 1: one-cycle pulse on a paddle reflection.
- `miss_l`, `miss_r` out 1: one-cycle pulses when the ball leaves past the left or right edge.

## Operation
- Position registers `hor`/`vert` are X_BITS+FRAC_BITS and Y_BITS+FRAC_BITS wide. `x`/`y` are their top bits.
- Step math:
  - dx = cos(theta)*speed and dy = sin(theta)*speed.
  - sin and cos are signed 8-bit, amplitude 127, taken from the registered `sin`/`cos` LUT modules.
  - Speed is zero-extended before the multiply; the product is sign-extended to the position width.
  - next = pos + d, wrapping modulo the register width.
- Left-moving means theta[MSB] == theta[MSB-1].
- FSM states:
  - **IDLE**: ball is centred (x = `2^(X_BITS-1)`, y = `2^(Y_BITS-1)`, fraction 0). On `serve`: load theta from `serve_dir`, load `speed` = `base_speed`, clear the rotation counter, go to PLAY.
  - **PLAY**: one step per accepted tick, evaluated in the order below.
  - **MISS**: position frozen; count HOLD_TICKS ticks, then recentre and go to IDLE.
- PLAY step evaluation:
  - **Paddle hit**:
    - Left-moving, next x = max column, and `lpaddle[next y]` set; or right-moving, next x = 0, and `rpaddle[next y]` set.
    - Action: theta <= N/2 − theta, `hor` held, `hit` pulsed, speed <= min(speed+1, MAX_SPEED).
  - **Miss**:
    - Left-moving and next x < x (wrap past the left edge) → `miss_l`.
    - Right-moving and next x > x → `miss_r`.
    - Action: pulse, go to MISS; `hor`/`vert` hold their pre-step values.
  - **Wall**:
    - Moving up (theta[MSB] = 1) with y = 0 and next y ≠ 0; or moving down with y ≠ 0 and next y = 0.
    - Action: theta <= N − theta, `vert` held.
  - **Corner** (hit and wall together): theta <= theta + N/2. Both axes held; `hit` pulses and speed increments.
  - **Otherwise**: `hor`/`vert` <= next.
  - **Curving**: the rotation counter advances on each PLAY tick. At ROT_PERIOD it sets a pending flag, and the flag wraps the counter back to 0. The pending flag applies theta+1 on the next reflection-free step when `curve_en` = 1, then clears.
- Theta arithmetic is modulo N.
- `serve` outside IDLE is ignored. Ticks in IDLE are ignored.

## Timing
- Reset (async assert, sync-free release) sets:
  - state IDLE
  - x, y at centre
  - theta 0, speed 0
  - `in_play`, `hit`, `miss_l`, `miss_r` at 0
  - counters 0
- Tick latency:
  - A tick sampled at edge t is registered.
  - The step commits at edge t+1, using LUT outputs for theta as of edge t.
  - Pulses are high for the cycle after edge t+1.
- Ticks must be ≥ 2 cycles apart. A tick in the cycle directly after an accepted tick is dropped.
- Serve takes effect at the edge that samples it. The first step uses the new theta only if the tick arrives ≥ 2 cycles later.
- Paddle inputs are sampled in the commit cycle.
- Reset mid-step discards the pending step.

## Test plan
- **Straight serve left**: reset, `serve_dir`=0, `base_speed`=4, no paddle. x increases from 8 to 15, then `miss_l` pulses once and `in_play` falls.
- **Paddle return**: `lpaddle`=16'hFFFF, serve left. `hit` pulses when x reaches 15; theta becomes 32 (N=64); speed becomes 5; x then decreases.
- **Wall bounce**: theta forced via serve plus curving to 40 (upward); ball reaches y=0. theta becomes 24 and y stays 0 on that step.
- **Corner**: ball at x=14, y=0 moving up-left with the paddle row set. Single step gives theta += 32 and both axes held.
- **Miss hold**: after a miss, x/y stay frozen for HOLD_TICKS ticks, then recentre; a `serve` sent during the hold is ignored.
- **Async reset**: assert `reset_n` low mid-PLAY between edges. Outputs return to reset values immediately, with no pulse.
